// File: rtl/cve2_pkg.sv
// Shared types for the CVE2 mult/div arbitration slice.
// Holds operator encodings and the arbiter FSM state enum.
package cve2_pkg;

   localparam int unsigned MD_W = 32;

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'd0,
      MD_OP_MULH = 2'd1,
      MD_OP_DIV  = 2'd2,
      MD_OP_REM  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } md_state_e;

endpackage

// File: rtl/cve2_rr_arb2.sv
// Two-way round-robin grant with last-grant memory.
// Ports: clk, rst (async, active-high), req[1:0] in, gnt[1:0] out (one-hot or 0).
module cve2_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // Index of the requester granted most recently; reset to 1 so
   // requester 0 wins the first tie.
   logic last;

   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= 1'b1;
      end else if (|gnt) begin
         last <= gnt[1];
      end
   end

endmodule

// File: rtl/cve2_multdiv_arbiter.sv
// Arbitrates the core ID stage (req 0) and an accelerator (req 1) onto one
// shared mult/div unit, with timeout-abort and kill for requester 0.
// Ports: clk_i, rst_i (async high); req_* valid/ready/op/signed/a/b per lane;
// kill_i; resp_valid_o/resp_ready_i per lane with shared resp_data_o/resp_err_o;
// unit drive (mult/div en/sel, operator, signed mode, operands, ready_id);
// unit_valid_i/unit_result_i back from the unit.
module cve2_multdiv_arbiter
   import cve2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  req_valid_i,
   output logic [1:0]  req_ready_o,
   input  logic [3:0]  req_op_i,
   input  logic [3:0]  req_signed_i,
   input  logic [63:0] req_a_i,
   input  logic [63:0] req_b_i,
   input  logic        kill_i,
   output logic [1:0]  resp_valid_o,
   input  logic [1:0]  resp_ready_i,
   output logic [31:0] resp_data_o,
   output logic        resp_err_o,
   output logic        mult_en_o,
   output logic        div_en_o,
   output logic        mult_sel_o,
   output logic        div_sel_o,
   output logic [1:0]  operator_o,
   output logic [1:0]  signed_mode_o,
   output logic [31:0] op_a_o,
   output logic [31:0] op_b_o,
   output logic        multdiv_ready_id_o,
   input  logic        unit_valid_i,
   input  logic [31:0] unit_result_i
);

   localparam logic [6:0] TMO_LAST = 7'(TIMEOUT_CYCLES - 1);

   md_state_e   state;
   md_state_e   state_nx;
   logic        owner;
   md_op_e      op;
   logic [1:0]  sgn;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] result;
   logic        err;
   logic [6:0]  cnt;

   logic [1:0]  arb_req;
   logic [1:0]  gnt;
   logic        accept;
   logic        kill_own;
   logic        timeout;
   logic        busy;

   // A kill in IDLE only masks requester 0; the accelerator may still win.
   assign arb_req = (state == ST_IDLE) ? (req_valid_i & {1'b1, ~kill_i}) : 2'b00;

   cve2_rr_arb2 u_arb (
      .clk (clk_i),
      .rst (rst_i),
      .req (arb_req),
      .gnt (gnt)
   );

   assign req_ready_o = gnt;
   assign accept      = |gnt;
   assign busy        = (state == ST_BUSY);
   assign kill_own    = kill_i & ~owner & (state != ST_IDLE);
   assign timeout     = (cnt == TMO_LAST);

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (accept) state_nx = ST_BUSY;
         end
         ST_BUSY: begin
            if (kill_own)          state_nx = ST_IDLE;
            else if (unit_valid_i) state_nx = ST_RESP;
            else if (timeout)      state_nx = ST_RESP;
         end
         ST_RESP: begin
            if (kill_own)                 state_nx = ST_IDLE;
            else if (resp_ready_i[owner]) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner  <= 1'b0;
         op     <= MD_OP_MULL;
         sgn    <= 2'b00;
         a      <= '0;
         b      <= '0;
         result <= '0;
         err    <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         owner <= gnt[1];
         op    <= md_op_e'(gnt[1] ? req_op_i[3:2] : req_op_i[1:0]);
         sgn   <= gnt[1] ? req_signed_i[3:2] : req_signed_i[1:0];
         a     <= gnt[1] ? req_a_i[63:32] : req_a_i[31:0];
         b     <= gnt[1] ? req_b_i[63:32] : req_b_i[31:0];
         cnt   <= '0;
      end else if (busy) begin
         cnt <= cnt + 7'd1;
         if (!kill_own) begin
            if (unit_valid_i) begin
               result <= unit_result_i;
               err    <= 1'b0;
            end else if (timeout) begin
               result <= '0;
               err    <= 1'b1;
            end
         end
      end
   end

   // Unit drive comes only from the registered request while BUSY.
   always_comb begin
      mult_en_o     = 1'b0;
      div_en_o      = 1'b0;
      mult_sel_o    = 1'b0;
      div_sel_o     = 1'b0;
      operator_o    = 2'b00;
      signed_mode_o = 2'b00;
      op_a_o        = '0;
      op_b_o        = '0;
      if (busy) begin
         operator_o    = op;
         signed_mode_o = sgn;
         op_a_o        = a;
         op_b_o        = b;
         unique case (op)
            MD_OP_MULL, MD_OP_MULH: begin
               mult_en_o  = 1'b1;
               mult_sel_o = 1'b1;
            end
            MD_OP_DIV, MD_OP_REM: begin
               div_en_o  = 1'b1;
               div_sel_o = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign multdiv_ready_id_o = busy & unit_valid_i & ~kill_own;

   // A killed response must not complete a handshake in the kill cycle.
   always_comb begin
      resp_valid_o = 2'b00;
      resp_data_o  = '0;
      resp_err_o   = 1'b0;
      if (state == ST_RESP) begin
         resp_data_o = result;
         resp_err_o  = err;
         if (!kill_own) resp_valid_o = owner ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: tb/tb_cve2_multdiv_arbiter.sv
// Self-checking bench for cve2_multdiv_arbiter.
// Table-driven transactions plus directed kill and reset sequences.
module tb_cve2_multdiv_arbiter;

   localparam int TMO = 8;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_op;
   logic [3:0]  req_signed;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic        kill;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        mult_en;
   logic        div_en;
   logic        mult_sel;
   logic        div_sel;
   logic [1:0]  operator;
   logic [1:0]  signed_mode;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        ready_id;
   logic        unit_valid;
   logic [31:0] unit_result;

   int checks = 0;
   int errors = 0;

   cve2_multdiv_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .req_valid_i        (req_valid),
      .req_ready_o        (req_ready),
      .req_op_i           (req_op),
      .req_signed_i       (req_signed),
      .req_a_i            (req_a),
      .req_b_i            (req_b),
      .kill_i             (kill),
      .resp_valid_o       (resp_valid),
      .resp_ready_i       (resp_ready),
      .resp_data_o        (resp_data),
      .resp_err_o         (resp_err),
      .mult_en_o          (mult_en),
      .div_en_o           (div_en),
      .mult_sel_o         (mult_sel),
      .div_sel_o          (div_sel),
      .operator_o         (operator),
      .signed_mode_o      (signed_mode),
      .op_a_o             (op_a),
      .op_b_o             (op_b),
      .multdiv_ready_id_o (ready_id),
      .unit_valid_i       (unit_valid),
      .unit_result_i      (unit_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  valid;
      int          owner;
      logic [1:0]  op;
      logic [1:0]  sgn;
      logic [31:0] a;
      logic [31:0] b;
      int          delay;
      logic [31:0] res;
      logic [31:0] data;
      logic        err;
      int          bp;
   } vec_t;

   vec_t tv[7];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v);
      logic [1:0] rv;
      int         nbusy;
      rv = (v.owner == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      req_valid  = v.valid;
      req_op     = (v.owner == 1) ? {v.op, ~v.op} : {~v.op, v.op};
      req_signed = (v.owner == 1) ? {v.sgn, ~v.sgn} : {~v.sgn, v.sgn};
      req_a      = (v.owner == 1) ? {v.a, ~v.a} : {~v.a, v.a};
      req_b      = (v.owner == 1) ? {v.b, ~v.b} : {~v.b, v.b};
      #1;
      chk("grant", 32'(req_ready), 32'(rv));
      chk("idle_en", 32'({mult_en, div_en}), 32'd0);
      nbusy = (v.delay < 0) ? TMO : v.delay + 1;
      for (int i = 0; i < nbusy; i++) begin
         @(negedge clk);
         req_valid   = 2'b00;
         req_op      = 4'($urandom);
         req_signed  = 4'($urandom);
         req_a       = {$urandom, $urandom};
         req_b       = {$urandom, $urandom};
         unit_valid  = (v.delay >= 0) && (i == v.delay);
         unit_result = unit_valid ? v.res : (32'hBAD0_0000 | 32'(i));
         #1;
         if (i == 0) begin
            chk("mult_en", 32'(mult_en), 32'(!v.op[1]));
            chk("mult_sel", 32'(mult_sel), 32'(!v.op[1]));
            chk("div_en", 32'(div_en), 32'(v.op[1]));
            chk("div_sel", 32'(div_sel), 32'(v.op[1]));
            chk("operator", 32'(operator), 32'(v.op));
            chk("signed", 32'(signed_mode), 32'(v.sgn));
            chk("op_a", op_a, v.a);
            chk("op_b", op_b, v.b);
         end
         chk("ready_id", 32'(ready_id), 32'(unit_valid));
         chk("busy_resp", 32'(resp_valid), 32'd0);
      end
      for (int k = 0; k <= v.bp; k++) begin
         @(negedge clk);
         unit_valid = 1'b0;
         req_valid  = 2'b11;
         resp_ready = (k == v.bp) ? rv : ~rv;
         #1;
         chk("resp_valid", 32'(resp_valid), 32'(rv));
         chk("resp_data", resp_data, v.data);
         chk("resp_err", 32'(resp_err), 32'(v.err));
         chk("resp_nogrant", 32'(req_ready), 32'd0);
         chk("resp_en", 32'({mult_en, div_en}), 32'd0);
      end
      @(negedge clk);
      req_valid  = 2'b00;
      resp_ready = 2'b00;
      #1;
      chk("post_resp", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      tv[0] = '{2'b01, 0, 2'd0, 2'b00, 32'd7, 32'd6, 3,
                32'd42, 32'd42, 1'b0, 0};
      tv[1] = '{2'b11, 1, 2'd2, 2'b11, 32'd100, 32'd7, 1,
                32'd14, 32'd14, 1'b0, 0};
      tv[2] = '{2'b11, 0, 2'd1, 2'b01, 32'hFFFF_FFF0, 32'd3, 2,
                32'hDEAD, 32'hDEAD, 1'b0, 1};
      tv[3] = '{2'b11, 1, 2'd3, 2'b10, 32'd23, 32'd7, 4,
                32'd2, 32'd2, 1'b0, 5};
      tv[4] = '{2'b10, 1, 2'd0, 2'b00, 32'h1111, 32'h2222, 0,
                32'h1234, 32'h1234, 1'b0, 0};
      tv[5] = '{2'b11, 0, 2'd2, 2'b00, 32'd9, 32'd0, -1,
                32'd0, 32'd0, 1'b1, 0};
      tv[6] = '{2'b01, 0, 2'd0, 2'b11, 32'd5, 32'd17, TMO - 1,
                32'h55, 32'h55, 1'b0, 0};

      rst         = 1'b1;
      req_valid   = 2'b00;
      req_op      = 4'd0;
      req_signed  = 4'd0;
      req_a       = 64'd0;
      req_b       = 64'd0;
      kill        = 1'b0;
      resp_ready  = 2'b00;
      unit_valid  = 1'b0;
      unit_result = 32'd0;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_resp", 32'(resp_valid), 32'd0);
      chk("rst_data", resp_data, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_en", 32'({mult_en, div_en, mult_sel, div_sel}), 32'd0);
      chk("rst_opa", op_a, 32'd0);
      chk("rst_id", 32'(ready_id), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int n = 0; n < 7; n++) run(tv[n]);

      // Kill of a requester-0 divide, coincident with unit_valid.
      @(negedge clk);
      req_valid = 2'b01;
      req_op    = 4'b0010;
      req_a     = {32'd0, 32'd50};
      req_b     = {32'd0, 32'd5};
      #1;
      chk("k0_grant", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("k0_div_en", 32'(div_en), 32'd1);
      @(negedge clk);
      kill        = 1'b1;
      unit_valid  = 1'b1;
      unit_result = 32'd10;
      #1;
      chk("k0_ready_id", 32'(ready_id), 32'd0);
      @(negedge clk);
      kill       = 1'b0;
      unit_valid = 1'b0;
      #1;
      chk("k0_div_off", 32'(div_en), 32'd0);
      chk("k0_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      chk("k0_still", 32'(resp_valid), 32'd0);
      req_valid = 2'b01;
      kill      = 1'b1;
      #1;
      chk("kill_idle", 32'(req_ready), 32'd0);
      @(negedge clk);
      req_valid = 2'b00;
      kill      = 1'b0;
      #1;
      chk("kill_idle_en", 32'({mult_en, div_en}), 32'd0);

      // The same kill against the accelerator is ignored.
      @(negedge clk);
      req_valid = 2'b10;
      req_op    = 4'b1000;
      #1;
      chk("k1_grant", 32'(req_ready), 32'd2);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("k1_div_en", 32'(div_en), 32'd1);
      @(negedge clk);
      kill        = 1'b1;
      unit_valid  = 1'b1;
      unit_result = 32'd77;
      #1;
      chk("k1_ready_id", 32'(ready_id), 32'd1);
      @(negedge clk);
      kill       = 1'b0;
      unit_valid = 1'b0;
      resp_ready = 2'b10;
      #1;
      chk("k1_resp", 32'(resp_valid), 32'd2);
      chk("k1_data", resp_data, 32'd77);
      @(negedge clk);
      resp_ready = 2'b00;

      // Reset in the middle of BUSY; last grant returns to 1.
      req_valid = 2'b01;
      req_op    = 4'b0000;
      req_a     = {32'd0, 32'd3};
      #1;
      chk("r_grant", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("r_busy", 32'(mult_en), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("r_en", 32'({mult_en, div_en, mult_sel, div_sel}), 32'd0);
      chk("r_opa", op_a, 32'd0);
      chk("r_resp", 32'(resp_valid), 32'd0);
      chk("r_id", 32'(ready_id), 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 2'b11;
      #1;
      chk("r_tie", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("r_no_resp", 32'(resp_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
